// File: rtl/sha1_ctrl_pkg.sv
// Shared definitions for the SHA1 result controller: FSM states, register map,
// CTRL/STATUS bit positions and a saturating increment helper.
package sha1_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TOUT = 2'd3
    } state_t;

    localparam int NUM_H = 5;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_H0     = 3'd2;
    localparam logic [2:0] ADDR_H1     = 3'd3;
    localparam logic [2:0] ADDR_H2     = 3'd4;
    localparam logic [2:0] ADDR_H3     = 3'd5;
    localparam logic [2:0] ADDR_H4     = 3'd6;
    localparam logic [2:0] ADDR_CYCLES = 3'd7;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLEAR  = 2;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_TIMEOUT = 2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sha1_job_timer.sv
// 16-bit saturating job cycle counter with a terminal-count flag at
// TIMEOUT_CYCLES-1; clear has priority over enable.
module sha1_job_timer
    import sha1_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_enable,
    output logic [15:0] o_count,
    output logic        o_terminal
);

    logic [15:0] r_count;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 16'd0;
        end else if (i_clear) begin
            r_count <= 16'd0;
        end else if (i_enable) begin
            r_count <= sat_inc16(r_count);
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sha1_result_ctrl.sv
// Avalon-MM front end for a SHA1 core: launches jobs, enforces a timeout,
// captures the digest and cycle count, and raises a level interrupt.
module sha1_result_ctrl
    import sha1_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int DIGEST_W       = 160
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                chipselect,
    input  logic [2:0]          address,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                irq,
    output logic                core_start,
    input  logic                core_done,
    input  logic [DIGEST_W-1:0] core_digest
);

    state_t      r_state;
    logic        r_core_start;
    logic        r_irq;
    logic        r_irq_en;
    logic [15:0] r_last_count;
    logic [31:0] r_h [NUM_H];
    logic [31:0] r_readdata;

    logic        w_ctrl_wr;
    logic        w_clear;
    logic        w_start;
    logic        w_start_accept;
    logic        w_irq_en_next;
    logic [15:0] w_count;
    logic        w_terminal;
    logic [31:0] w_rd_mux;

    assign w_ctrl_wr      = chipselect && write && (address == ADDR_CTRL);
    assign w_clear        = w_ctrl_wr && writedata[CTRL_CLEAR];
    assign w_start        = w_ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_CLEAR];
    assign w_start_accept = w_start && (r_state != ST_RUN);
    // irq must react in the same edge as an irq_en write, so use the incoming value.
    assign w_irq_en_next  = w_ctrl_wr ? writedata[CTRL_IRQ_EN] : r_irq_en;

    sha1_job_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_start_accept),
        .i_enable  (r_state == ST_RUN),
        .o_count   (w_count),
        .o_terminal(w_terminal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_core_start <= 1'b0;
            r_irq        <= 1'b0;
            r_irq_en     <= 1'b0;
            r_last_count <= 16'd0;
            // NOTE: the digest array is cleared on reset because software may read it at any time.
            for (int i = 0; i < NUM_H; i++) r_h[i] <= 32'd0;
        end else begin
            r_core_start <= 1'b0;
            if (w_ctrl_wr) r_irq_en <= writedata[CTRL_IRQ_EN];
            r_irq <= w_irq_en_next && ((r_state == ST_DONE) || (r_state == ST_TOUT));

            if (w_clear) begin
                r_state <= ST_IDLE;
                r_irq   <= 1'b0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        // Digest arriving on the terminal cycle still counts as success.
                        if (core_done) begin
                            r_state      <= ST_DONE;
                            r_last_count <= sat_inc16(w_count);
                            r_irq        <= w_irq_en_next;
                            for (int i = 0; i < NUM_H; i++)
                                r_h[i] <= core_digest[DIGEST_W-1-32*i -: 32];
                        end else if (w_terminal) begin
                            r_state <= ST_TOUT;
                            r_irq   <= w_irq_en_next;
                        end
                    end
                    default: begin
                        if (w_start) begin
                            r_state      <= ST_RUN;
                            r_core_start <= 1'b1;
                            r_irq        <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // NOTE: every path assigns w_rd_mux via the leading default, so no latch is inferred.
    always_comb begin
        w_rd_mux = 32'd0;
        case (address)
            ADDR_CTRL:   w_rd_mux = {30'd0, r_irq_en, 1'b0};
            ADDR_STATUS: w_rd_mux = {29'd0, r_state == ST_TOUT, r_state == ST_DONE, r_state == ST_RUN};
            ADDR_H0:     w_rd_mux = r_h[0];
            ADDR_H1:     w_rd_mux = r_h[1];
            ADDR_H2:     w_rd_mux = r_h[2];
            ADDR_H3:     w_rd_mux = r_h[3];
            ADDR_H4:     w_rd_mux = r_h[4];
            ADDR_CYCLES: w_rd_mux = {16'd0, r_last_count};
            default:     w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
        end else begin
            r_readdata <= chipselect ? w_rd_mux : 32'd0;
        end
    end

    assign readdata   = r_readdata;
    assign irq        = r_irq;
    assign core_start = r_core_start;

endmodule

// File: doc/sha1_result_ctrl.md
SHA1_RESULT_CTRL -- requirements
Module: sha1_result_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of RUN cycles allowed before timeout (range 2..65535).
REQ-002 SHALL have parameter DIGEST_W, default 160: digest width from the SHA1 core; fixed at 5 x 32.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port chipselect, input, 1: Avalon-MM slave select.
REQ-006 SHALL have port address, input, 3: word address.
REQ-007 SHALL have port write, input, 1: write strobe, qualified by chipselect.
REQ-008 SHALL have port writedata, input, 32: write data.
REQ-009 SHALL have port readdata, output, 32: registered read data.
REQ-010 SHALL have port irq, output, 1: level interrupt.
REQ-011 SHALL have port core_start, output, 1: one-cycle start pulse to the SHA1 core.
REQ-012 SHALL have port core_done, input, 1: one-cycle digest-valid pulse from the core.
REQ-013 SHALL have port core_digest, input, 160: digest, H0 in bits 159:128, valid when core_done=1.

Function
REQ-014 SHALL decode writes at addr 0 (CTRL): bit0 start, bit1 irq_en (stored), bit2 clear; bits 0 and 2 self-clearing.
REQ-015 SHALL decode reads: addr 0 {30'b0, irq_en, 1'b0}; addr 1 STATUS {29'b0, timeout, done, busy}; addr 2..6 digest H0..H4; addr 7 cycle count of the last job (zero-extended 16 bits).
REQ-016 SHALL update readdata every clock from the current address, with 1-cycle latency and no read strobe; it SHALL return 0 when chipselect=0.
REQ-017 SHALL implement FSM states IDLE, RUN, DONE, TOUT.
REQ-018 IDLE/DONE/TOUT + start: SHALL assert core_start for exactly 1 cycle, clear the done/timeout flags and the cycle counter, and enter RUN next cycle.
REQ-019 RUN + core_done: SHALL capture core_digest into H0..H4, latch the cycle count, and enter DONE in the same edge.
REQ-020 RUN, counter = TIMEOUT_CYCLES-1, no core_done: SHALL enter TOUT; digest registers SHALL keep their old values.
REQ-021 core_done and timeout in the same cycle: core_done SHALL win (enter DONE).
REQ-022 start while in RUN: SHALL be ignored (no core_start, counter not cleared).
REQ-023 core_done outside RUN: SHALL be ignored; digest unchanged.
REQ-024 clear (any state): SHALL force IDLE and clear the done/timeout flags; digest and irq_en SHALL be retained.
REQ-025 start and clear in the same write: clear SHALL win; no core_start.
REQ-026 The cycle counter SHALL be 16 bits, increment once per RUN cycle starting at 0, and saturate rather than wrap.
REQ-027 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; timeout SHALL be 1 in TOUT only.
REQ-028 irq SHALL be registered as irq_en & (done | timeout) and deassert the cycle after clear, start, or irq_en=0.

Reset
REQ-029 On reset_n=0, asynchronously: FSM=IDLE; readdata, irq, core_start, irq_en, counter, latched count and H0..H4 SHALL all be 0.
REQ-030 Reset asserted during RUN SHALL abort the job; a core_done in the first cycle after release SHALL be ignored.

Structure
REQ-031 A shared package sha1_ctrl_pkg SHALL hold the FSM state enum, register address constants and CTRL/STATUS bit indices.
REQ-032 The timeout/cycle counter SHALL be a sub-module sha1_job_timer (clear, enable, saturating count, terminal flag).

Verification
REQ-033 Write 0x3 to addr 0; core_done at 5 cycles with digest 0x67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0 -> core_start exactly 1 pulse, DONE; addr 2 reads 0x67452301 and addr 6 reads 0xC3D2E1F0 one cycle after address; addr 7 = 5; irq=1.
REQ-034 TIMEOUT_CYCLES=8, no core_done -> STATUS reads 0x4 after 8 RUN cycles; digest unchanged; irq=1 only if irq_en=1.
REQ-035 core_done coincident with the terminal count -> STATUS reads 0x2 and the digest is captured.
REQ-036 Start rewritten during RUN; then 0x5 (start+clear) written in DONE -> single core_start overall; FSM ends in IDLE with STATUS 0x0.
REQ-037 reset_n pulsed low mid-RUN, then core_done -> all registers 0, STATUS 0x0, done not set.
